// File: rtl/branch_predict_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_predict_unit_pkg
// Shared pipeline definitions for the branch prediction unit.
//   CTR_*          2-bit saturating counter encodings
//   sat_ctr_next   next counter value after a resolved branch
//   branch_target  PC-relative target from a halfword-unit immediate
// ---------------------------------------------------------------------------
package branch_predict_unit_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Counter moves one step toward the resolved direction and sticks at the ends.
  function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'b01;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

  // Immediate is in halfwords; a 32-bit shift drops bit 31, matching {imme[30:0],1'b0}.
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] imme);
    return pc + (imme << 1);
  endfunction

endpackage

// File: rtl/branch_predict_unit_bht_table.sv
// ---------------------------------------------------------------------------
// bht_table
// ENTRIES x 2-bit saturating counter array.
//   clk_i, rst_i  clock and asynchronous active-low reset (entries -> INIT_CTR)
//   rd_idx        ID lookup index (combinational read)
//   rd_predict    MSB of the addressed counter (1 = predict taken)
//   wr_en         train the entry at wr_idx on this rising edge
//   wr_idx        EX training index
//   wr_taken      resolved direction used for training
// ---------------------------------------------------------------------------
module bht_table
  import branch_predict_unit_pkg::*;
#(
  parameter int         ENTRIES  = 16,
  parameter int         IDX_W    = $clog2(ENTRIES),
  parameter logic [1:0] INIT_CTR = CTR_WNT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_predict,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr_q [ENTRIES];

  // Read returns the registered value, so a same-cycle write is seen by ID only next cycle.
  assign rd_predict = ctr_q[rd_idx][1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= INIT_CTR;
      end
    end else if (wr_en) begin
      ctr_q[wr_idx] <= sat_ctr_next(ctr_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
// Branch history table of 2-bit saturating counters beside the ID stage.
//   clk_i, rst_i       clock and asynchronous active-low reset
//   id_branch_i        ID instruction is a conditional branch
//   id_pc_i, id_imme_i ID PC and halfword-unit immediate
//   predict_o          taken prediction for the ID instruction
//   pred_target_o      id_pc_i + 2*id_imme_i (always driven)
//   ex_branch_i        EX instruction is a branch
//   ex_predict_i       prediction that was made for it
//   ex_taken_i         resolved outcome
//   ex_pc_i, ex_imme_i EX PC and immediate
//   flush_o            mispredict: flush IF/ID and ID/EX
//   redirect_pc_o      corrected fetch PC while flush_o = 1, else 0
//   branch_cnt_o       resolved branches since reset
//   mispred_cnt_o      mispredictions since reset
// ---------------------------------------------------------------------------
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int         ENTRIES   = 16,
  parameter int         INDEX_LSB = 2,
  parameter logic [1:0] INIT_CTR  = CTR_WNT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_branch_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_imme_i,
  output logic        predict_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_branch_i,
  input  logic        ex_predict_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imme_i,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] id_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             table_predict;
  logic             mispredict;
  logic [31:0]      branch_cnt_q;
  logic [31:0]      mispred_cnt_q;

  assign id_idx = id_pc_i[INDEX_LSB+IDX_W-1:INDEX_LSB];
  assign ex_idx = ex_pc_i[INDEX_LSB+IDX_W-1:INDEX_LSB];

  bht_table #(
    .ENTRIES  (ENTRIES),
    .IDX_W    (IDX_W),
    .INIT_CTR (INIT_CTR)
  ) u_bht_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx     (id_idx),
    .rd_predict (table_predict),
    .wr_en      (ex_branch_i),
    .wr_idx     (ex_idx),
    .wr_taken   (ex_taken_i)
  );

  assign predict_o     = id_branch_i & table_predict;
  assign pred_target_o = branch_target(id_pc_i, id_imme_i);

  // Redirect goes to the side the prediction did not take; zero when nothing is flushed.
  always_comb begin
    mispredict    = ex_branch_i & (ex_predict_i ^ ex_taken_i);
    redirect_pc_o = 32'd0;
    if (mispredict) begin
      redirect_pc_o = ex_taken_i ? branch_target(ex_pc_i, ex_imme_i) : ex_pc_i + 32'd4;
    end
  end

  assign flush_o = mispredict;

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      if (ex_branch_i) branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (mispredict)  mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
// Directed scenarios plus random traffic, checked every cycle against a
// behavioural model of the predictor (integer counters, plain arithmetic).
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

  localparam int ENTRIES = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_branch_i;
  logic [31:0] id_pc_i;
  logic [31:0] id_imme_i;
  logic        predict_o;
  logic [31:0] pred_target_o;
  logic        ex_branch_i;
  logic        ex_predict_i;
  logic        ex_taken_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_imme_i;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  int checks = 0;
  int errors = 0;

  int          model_ctr [ENTRIES];
  int unsigned model_branches;
  int unsigned model_mispred;
  int unsigned saved_mispred;

  branch_predict_unit #(
    .ENTRIES   (ENTRIES),
    .INDEX_LSB (2),
    .INIT_CTR  (2'b01)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_branch_i   (id_branch_i),
    .id_pc_i       (id_pc_i),
    .id_imme_i     (id_imme_i),
    .predict_o     (predict_o),
    .pred_target_o (pred_target_o),
    .ex_branch_i   (ex_branch_i),
    .ex_predict_i  (ex_predict_i),
    .ex_taken_i    (ex_taken_i),
    .ex_pc_i       (ex_pc_i),
    .ex_imme_i     (ex_imme_i),
    .flush_o       (flush_o),
    .redirect_pc_o (redirect_pc_o),
    .branch_cnt_o  (branch_cnt_o),
    .mispred_cnt_o (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int entryOf(input logic [31:0] pc);
    return int'((pc / 32'd4) % ENTRIES);
  endfunction

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) model_ctr[i] = 1;
    model_branches = 0;
    model_mispred  = 0;
  endtask

  // One rising edge of the predictor, as described by its rules.
  task automatic modelClock();
    int e;
    if (ex_branch_i) begin
      e = entryOf(ex_pc_i);
      if (ex_taken_i) model_ctr[e] = (model_ctr[e] < 3) ? model_ctr[e] + 1 : 3;
      else            model_ctr[e] = (model_ctr[e] > 0) ? model_ctr[e] - 1 : 0;
      model_branches++;
      if (ex_predict_i != ex_taken_i) model_mispred++;
    end
  endtask

  task automatic checkOutput();
    logic        exp_pred;
    logic        exp_flush;
    logic [31:0] exp_redirect;
    exp_pred  = id_branch_i && (model_ctr[entryOf(id_pc_i)] >= 2);
    exp_flush = ex_branch_i && (ex_predict_i != ex_taken_i);
    exp_redirect = 32'd0;
    if (exp_flush) exp_redirect = ex_taken_i ? ex_pc_i + ex_imme_i * 32'd2 : ex_pc_i + 32'd4;
    compareVal("predict",     {31'd0, predict_o}, {31'd0, exp_pred});
    compareVal("pred_target", pred_target_o, id_pc_i + id_imme_i * 32'd2);
    compareVal("flush",       {31'd0, flush_o}, {31'd0, exp_flush});
    compareVal("redirect_pc", redirect_pc_o, exp_redirect);
    compareVal("branch_cnt",  branch_cnt_o, model_branches);
    compareVal("mispred_cnt", mispred_cnt_o, model_mispred);
  endtask

  task automatic applyStimulus(input logic idb, input logic [31:0] idpc, input logic [31:0] idimm,
                               input logic exb, input logic expred, input logic extaken,
                               input logic [31:0] expc, input logic [31:0] eximm);
    id_branch_i  = idb;
    id_pc_i      = idpc;
    id_imme_i    = idimm;
    ex_branch_i  = exb;
    ex_predict_i = expred;
    ex_taken_i   = extaken;
    ex_pc_i      = expc;
    ex_imme_i    = eximm;
  endtask

  // Model check at the falling edge, then advance one rising edge.
  task automatic step();
    @(negedge clk_i);
    checkOutput();
    @(posedge clk_i);
    if (rst_i) modelClock();
    #1;
  endtask

  task automatic randomStimulus();
    logic [31:0] idpc;
    logic [31:0] expc;
    logic        exb;
    logic        tk;
    logic        pr;
    idpc = ($urandom_range(0, 3) == 0) ? ($urandom & ~32'd3) : 32'($urandom_range(0, 63)) * 32'd4;
    expc = ($urandom_range(0, 3) == 0) ? ($urandom & ~32'd3) : 32'($urandom_range(0, 63)) * 32'd4;
    exb  = ($urandom_range(0, 2) != 0);
    tk   = $urandom_range(0, 1) == 1;
    pr   = ($urandom_range(0, 1) == 1) ? (model_ctr[entryOf(expc)] >= 2) : ($urandom_range(0, 1) == 1);
    applyStimulus($urandom_range(0, 1) == 1, idpc, $urandom, exb, pr, tk, expc, $urandom);
  endtask

  initial begin
    rst_i = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    modelReset();
    @(negedge clk_i);
    checkOutput();
    compareVal("reset_branch_cnt",  branch_cnt_o, 32'd0);
    compareVal("reset_mispred_cnt", mispred_cnt_o, 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Fresh lookup: weakly not-taken, target 0x40 + 2*0x10.
    applyStimulus(1'b1, 32'h40, 32'h10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #3;
    compareVal("t1_predict", {31'd0, predict_o}, 32'd0);
    compareVal("t1_target",  pred_target_o, 32'h60);
    step();

    // Two taken updates predicted not-taken: each one flushes to the target.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h10);
      #3;
      compareVal("t2_flush",    {31'd0, flush_o}, 32'd1);
      compareVal("t2_redirect", redirect_pc_o, 32'h60);
      step();
    end
    applyStimulus(1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #3;
    compareVal("t2_predict_after", {31'd0, predict_o}, 32'd1);
    step();

    // Saturation at strong taken, then walk down to strong not-taken.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h40, 32'h0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h10);
      step();
    end
    applyStimulus(1'b1, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h10);
    step();
    applyStimulus(1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #3;
    compareVal("t3_weak_taken", {31'd0, predict_o}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h10);
      step();
    end
    applyStimulus(1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #3;
    compareVal("t3_strong_nt", {31'd0, predict_o}, 32'd0);
    step();

    // Predicted taken, actually not taken: fall-through redirect.
    saved_mispred = model_mispred;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h20);
    #3;
    compareVal("t4_flush",    {31'd0, flush_o}, 32'd1);
    compareVal("t4_redirect", redirect_pc_o, 32'h84);
    step();
    compareVal("t4_mispred_inc", mispred_cnt_o, saved_mispred + 1);

    // Entry back to 01, then read and train the same entry in one cycle.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0);
    step();
    applyStimulus(1'b1, 32'h40, 32'h0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
    #3;
    compareVal("t5_same_cycle", {31'd0, predict_o}, 32'd0);
    step();
    applyStimulus(1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #3;
    compareVal("t5_next_cycle", {31'd0, predict_o}, 32'd1);
    step();
    applyStimulus(1'b1, 32'h40 + 4 * ENTRIES, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #3;
    compareVal("t5_alias", {31'd0, predict_o}, 32'd1);
    step();

    // Wrap-around PC arithmetic.
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0010);
    #3;
    compareVal("wrap_target",   pred_target_o, 32'h0000_0004);
    compareVal("wrap_redirect", redirect_pc_o, 32'h0000_0010);
    step();

    for (int n = 0; n < 400; n++) begin
      randomStimulus();
      step();
    end

    // Train 0x40 hard, then reset with no clock edge in between.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h40, 32'h0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
      step();
    end
    applyStimulus(1'b1, 32'h40, 32'h0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
    #1;
    compareVal("t6_trained", {31'd0, predict_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    modelReset();
    compareVal("t6_branch_cnt",  branch_cnt_o, 32'd0);
    compareVal("t6_mispred_cnt", mispred_cnt_o, 32'd0);
    compareVal("t6_predict",     {31'd0, predict_o}, 32'd0);
    checkOutput();
    for (int k = 0; k < 2; k++) step();
    rst_i = 1'b1;
    step();

    for (int n = 0; n < 200; n++) begin
      randomStimulus();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
